enemy_swarm_mover: RTL and testbench

Parametrised multi-object flight controller for the dragon/enemy layer. Drives up to N_OBJ independent fliers in fixed-point coordinates, once per video frame. Each flier spawns at the right edge under pseudo-random control, drifts left with random vertical zig-zag bounded in Y, and retires on a shot hit or on leaving the screen. Outputs feed the per-object drawing and collision blocks directly.

---
 rtl/swarm_pkg.sv | 20 ++
 rtl/swarm_lfsr.sv | 23 ++
 rtl/enemy_swarm_mover.sv | 177 +++++++++++++++++
 tb/tb_enemy_swarm_mover.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/swarm_pkg.sv
// swarm_pkg: shared state enum, fixed-point types and LFSR constants for the enemy swarm mover
package swarm_pkg;

    typedef enum logic [1:0] {IDLE, FLYING, DYING} obj_state_t;

    localparam int FP_SHIFT = 6;

    typedef logic signed [31:0] fp_t;
    typedef logic signed [10:0] pix_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Galois feedback mask for x^16 + x^15 + x^13 + x^4 + 1
    localparam logic [15:0] LFSR_TAPS = 16'hD008;

    // Arithmetic shift down to pixels, keeping the low 11 bits
    function automatic pix_t fp_to_pix(input fp_t p);
        return p[FP_SHIFT+10:FP_SHIFT];
    endfunction

endpackage

// File: rtl/swarm_lfsr.sv
// swarm_lfsr: 16-bit Galois LFSR stepped once per frame, exposes its low 11 bits
module swarm_lfsr
    import swarm_pkg::*;
(
    input  logic        clk,
    input  logic        resetN,
    input  logic        i_en,
    output logic [10:0] o_rand
);

    logic [15:0] r_lfsr;

    // Shift right; when the bit falling out is 1, fold the tap mask back in
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)
            r_lfsr <= LFSR_SEED;
        else if (i_en)
            r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 16'h0000);
    end

    assign o_rand = r_lfsr[10:0];

endmodule

// File: rtl/enemy_swarm_mover.sv
// enemy_swarm_mover: per-frame spawn, zig-zag drift and retire control for N_OBJ fliers.
// Define ENEMY_SWARM_DEATH_ANIM_EN to insert a timed DYING state between a hit and IDLE.
module enemy_swarm_mover
    import swarm_pkg::*;
#(
    parameter int N_OBJ     = 4,
    parameter int X_SPEED   = -120,
    parameter int Y_SPEED   = 70,
    parameter int START_X   = 680,
    parameter int START_Y   = 60,
    parameter int Y_MIN     = 20,
    parameter int Y_MAX     = 180,
    parameter int EXIT_X    = -50,
    parameter int SPAWN_LO  = 550,
    parameter int SPAWN_HI  = 570,
    parameter int SPAWN_GAP = 30
`ifdef ENEMY_SWARM_DEATH_ANIM_EN
    , parameter int DEATH_FRAMES = 16
`endif
)
(
    input  logic             clk,
    input  logic             resetN,
    input  logic             startOfFrame,
    input  logic             pause,
    input  logic [10:0]      RNG,
    input  logic [N_OBJ-1:0] hit,
    output pix_t             topLeftX [N_OBJ],
    output pix_t             topLeftY [N_OBJ],
    output logic [N_OBJ-1:0] active,
    output logic [N_OBJ-1:0] dying,
    output logic             spawnPulse
);

    localparam fp_t         P_SX   = fp_t'(START_X) <<< FP_SHIFT;
    localparam fp_t         P_SY   = fp_t'(START_Y) <<< FP_SHIFT;
    localparam fp_t         P_DX   = fp_t'(X_SPEED);
    localparam fp_t         P_DY   = fp_t'(Y_SPEED);
    localparam pix_t        P_YMIN = pix_t'(Y_MIN);
    localparam pix_t        P_YMAX = pix_t'(Y_MAX);
    localparam pix_t        P_EXIT = pix_t'(EXIT_X);
    localparam logic [11:0] P_SLO  = 12'(SPAWN_LO);
    localparam logic [11:0] P_SHI  = 12'(SPAWN_HI);
    localparam logic [11:0] P_ZLO  = 12'd300;
    localparam logic [11:0] P_ZHI  = 12'd600;
    localparam logic [7:0]  P_GAP  = 8'(SPAWN_GAP);
`ifdef ENEMY_SWARM_DEATH_ANIM_EN
    localparam logic [7:0]  P_DEATH = 8'(DEATH_FRAMES);
`endif

    logic [10:0]      w_rand;
    logic             w_step;
    logic [11:0]      w_r0;
    logic [N_OBJ-1:0] w_idle;
    logic [N_OBJ-1:0] w_spawn_oh;
    logic             w_spawn;
    logic [7:0]       r_gap;

    swarm_lfsr u_lfsr (
        .clk    (clk),
        .resetN (resetN),
        .i_en   (startOfFrame),
        .o_rand (w_rand)
    );

    assign w_step     = startOfFrame && !pause;
    assign w_r0       = {1'b0, RNG} + {1'b0, w_rand};
    assign w_spawn_oh = w_idle & (~w_idle + N_OBJ'(1));
    assign w_spawn    = w_step && (r_gap == 8'd0) && (w_r0 >= P_SLO) && (w_r0 < P_SHI) && (|w_idle);

    // Spawn spacing counter and the one-cycle spawn strobe
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_gap      <= 8'd0;
            spawnPulse <= 1'b0;
        end else begin
            spawnPulse <= w_spawn;
            if (w_spawn)
                r_gap <= P_GAP;
            else if (w_step && r_gap != 8'd0)
                r_gap <= r_gap - 8'd1;
        end
    end

    for (genvar i = 0; i < N_OBJ; i++) begin : g_obj
        obj_state_t  r_state, w_state_nxt;
        fp_t         r_px, r_py, w_px_nxt, w_py_nxt;
        logic        r_up, w_up_nxt, w_up_new, w_go_idle;
        logic [11:0] w_r;
        pix_t        w_x, w_y;
`ifdef ENEMY_SWARM_DEATH_ANIM_EN
        logic [7:0]  r_tmr, w_tmr_nxt;
`endif

        assign w_r      = w_r0 + 12'(97 * i);
        assign w_x      = fp_to_pix(r_px);
        assign w_y      = fp_to_pix(r_py);
        assign w_up_new = (w_y < P_YMIN) ? 1'b0 :
                          (w_y > P_YMAX) ? 1'b1 :
                          (w_r >= P_ZLO && w_r < P_ZHI) ? !r_up : r_up;

        // Next state: a hit beats the frame step; every return to IDLE re-homes the flier
        always_comb begin
            w_state_nxt = r_state;
            w_px_nxt    = r_px;
            w_py_nxt    = r_py;
            w_up_nxt    = r_up;
            w_go_idle   = 1'b0;
`ifdef ENEMY_SWARM_DEATH_ANIM_EN
            w_tmr_nxt   = r_tmr;
`endif
            if (r_state == FLYING && hit[i]) begin
`ifdef ENEMY_SWARM_DEATH_ANIM_EN
                w_state_nxt = DYING;
                w_tmr_nxt   = P_DEATH;
`else
                w_go_idle   = 1'b1;
`endif
            end else if (r_state == FLYING && w_step) begin
                if (w_x <= P_EXIT) begin
                    w_go_idle = 1'b1;
                end else begin
                    w_up_nxt = w_up_new;
                    w_px_nxt = r_px + P_DX;
                    w_py_nxt = w_up_new ? r_py - P_DY : r_py + P_DY;
                end
            end else if (r_state == IDLE && w_spawn && w_spawn_oh[i]) begin
                w_state_nxt = FLYING;
`ifdef ENEMY_SWARM_DEATH_ANIM_EN
            end else if (r_state == DYING && w_step) begin
                if (r_tmr <= 8'd1)
                    w_go_idle = 1'b1;
                else
                    w_tmr_nxt = r_tmr - 8'd1;
`endif
            end
            if (w_go_idle) begin
                w_state_nxt = IDLE;
                w_px_nxt    = P_SX;
                w_py_nxt    = P_SY;
                w_up_nxt    = 1'b0;
            end
        end

        // Per-object state, position and direction registers
        always_ff @(posedge clk or negedge resetN) begin
            if (!resetN) begin
                r_state <= IDLE;
                r_px    <= P_SX;
                r_py    <= P_SY;
                r_up    <= 1'b0;
`ifdef ENEMY_SWARM_DEATH_ANIM_EN
                r_tmr   <= 8'd0;
`endif
            end else begin
                r_state <= w_state_nxt;
                r_px    <= w_px_nxt;
                r_py    <= w_py_nxt;
                r_up    <= w_up_nxt;
`ifdef ENEMY_SWARM_DEATH_ANIM_EN
                r_tmr   <= w_tmr_nxt;
`endif
            end
        end

        assign topLeftX[i] = w_x;
        assign topLeftY[i] = w_y;
        assign active[i]   = (r_state == FLYING);
        assign w_idle[i]   = (r_state == IDLE);
`ifdef ENEMY_SWARM_DEATH_ANIM_EN
        assign dying[i]    = (r_state == DYING);
`else
        assign dying[i]    = 1'b0;
`endif
    end

endmodule

// File: tb/tb_enemy_swarm_mover.sv
// tb_enemy_swarm_mover: randomized frame stimulus checked against a behavioural swarm model
module tb_enemy_swarm_mover;

    localparam int N = 4;

    logic                clk = 1'b0;
    logic                resetN = 1'b0;
    logic                startOfFrame = 1'b0;
    logic                pause = 1'b0;
    logic [10:0]         RNG = '0;
    logic [N-1:0]        hit = '0;
    logic signed [10:0]  topLeftX [N];
    logic signed [10:0]  topLeftY [N];
    logic [N-1:0]        active;
    logic [N-1:0]        dying;
    logic                spawnPulse;

    int          mx [N];
    int          my [N];
    int          mdir [N];
    int          mtmr [N];
    bit          mfly [N];
    bit          mdie [N];
    int          mgap;
    bit          mspawn;
    logic [15:0] mlfsr;
    int          n_vec = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    enemy_swarm_mover #(.N_OBJ(N)) dut (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .pause        (pause),
        .RNG          (RNG),
        .hit          (hit),
        .topLeftX     (topLeftX),
        .topLeftY     (topLeftY),
        .active       (active),
        .dying        (dying),
        .spawnPulse   (spawnPulse)
    );

    function automatic int pix(input int v);
        return v >>> 6;
    endfunction

    // One step of the polynomial x^16+x^15+x^13+x^4+1 in right-shifting Galois form
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        int v;
        v = int'(s);
        return 16'((v % 2 == 1) ? ((v / 2) ^ 'hD008) : (v / 2));
    endfunction

    task automatic home(input int i);
        mx[i] = 680 * 64;
        my[i] = 60 * 64;
        mdir[i] = 1;
        mfly[i] = 0;
        mdie[i] = 0;
        mtmr[i] = 0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) home(i);
        mgap = 0;
        mspawn = 0;
        mlfsr = 16'hACE1;
    endtask

    task automatic kill(input int i);
`ifdef ENEMY_SWARM_DEATH_ANIM_EN
        mfly[i] = 0;
        mdie[i] = 1;
        mtmr[i] = 16;
`else
        home(i);
`endif
    endtask

    task automatic model_frame(input logic [10:0] rng, input logic [N-1:0] h, input bit p);
        int r [N];
        int sel;
        int py;
        sel = -1;
        for (int i = 0; i < N; i++) r[i] = (int'(rng) + int'(mlfsr[10:0]) + 97 * i) % 4096;
        if (!p && mgap == 0 && r[0] >= 550 && r[0] < 570)
            for (int i = 0; i < N; i++) if (sel < 0 && !mfly[i] && !mdie[i]) sel = i;
        for (int i = 0; i < N; i++) begin
            if (mfly[i] && h[i]) kill(i);
            else if (!p && mfly[i]) begin
                if (pix(mx[i]) <= -50) home(i);
                else begin
                    py = pix(my[i]);
                    if (py < 20) mdir[i] = 1;
                    else if (py > 180) mdir[i] = -1;
                    else if (r[i] >= 300 && r[i] < 600) mdir[i] = -mdir[i];
                    mx[i] = mx[i] - 120;
                    my[i] = my[i] + 70 * mdir[i];
                end
            end else if (!p && mdie[i]) begin
                mtmr[i] = mtmr[i] - 1;
                if (mtmr[i] == 0) home(i);
            end
        end
        mspawn = (sel >= 0);
        if (sel >= 0) mfly[sel] = 1;
        if (!p) mgap = (sel >= 0) ? 30 : (mgap > 0 ? mgap - 1 : 0);
        mlfsr = lfsr_next(mlfsr);
    endtask

    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("%s x%0d", tag, i), topLeftX[i], 11'(pix(mx[i])));
            chk($sformatf("%s y%0d", tag, i), topLeftY[i], 11'(pix(my[i])));
            chk($sformatf("%s active%0d", tag, i), active[i], mfly[i]);
            chk($sformatf("%s dying%0d", tag, i), dying[i], mdie[i]);
        end
        chk($sformatf("%s spawn", tag), spawnPulse, mspawn);
    endtask

    task automatic frame(input logic [10:0] rng, input logic [N-1:0] h, input bit p);
        @(negedge clk);
        RNG = rng;
        hit = h;
        pause = p;
        startOfFrame = 1'b1;
        model_frame(rng, h, p);
        @(negedge clk);
        startOfFrame = 1'b0;
        hit = '0;
        pause = 1'b0;
        RNG = 11'($urandom_range(0, 2047));
        check_all("frame");
        @(negedge clk);
        chk("pulse_end", spawnPulse, 0);
    endtask

    task automatic hit_only(input logic [N-1:0] h);
        @(negedge clk);
        hit = h;
        for (int i = 0; i < N; i++) if (mfly[i] && h[i]) kill(i);
        mspawn = 0;
        @(negedge clk);
        hit = '0;
        check_all("hit");
    endtask

    // Picks RNG so r_0 lands in (want) or away from (!want) the spawn window when it can
    function automatic logic [10:0] pick_rng(input bit want);
        int l;
        int t;
        int v;
        l = int'(mlfsr[10:0]);
        t = 550 + int'($urandom_range(0, 19));
        if (want && l <= t) return 11'(t - l);
        v = int'($urandom_range(0, 2047));
        if (!want && ((v + l) % 4096) >= 550 && ((v + l) % 4096) < 570) v = v ^ 'h400;
        return 11'(v);
    endfunction

    initial begin
        int k;
        int sel;
        logic [N-1:0] h;
        bit p;
        model_reset();
        repeat (3) @(negedge clk);
        check_all("reset");
        chk("reset_x_const", topLeftX[0], 680);
        chk("reset_y_const", topLeftY[0], 60);
        resetN = 1'b1;
        repeat (5) frame(11'd0, '0, 1'b0);
        k = 0;
        while (!mfly[0] && k < 80) begin
            frame(pick_rng(1'b1), '0, 1'b0);
            k++;
        end
        chk("spawn0_active", active[0], 1);
        if (k > 0) begin
            frame(pick_rng(1'b0), '0, 1'b0);
            chk("first_step_x", topLeftX[0], 678);
        end
        repeat (30) frame(pick_rng(1'b1), '0, 1'b0);
        repeat (150) frame(pick_rng(1'b1), '0, 1'b0);
        frame(pick_rng(1'b0), 4'b0010, 1'b0);
        repeat (20) frame(pick_rng(1'b0), '0, 1'b0);
        repeat (10) frame(pick_rng(1'b1), '0, 1'b1);
        repeat (700) begin
            sel = int'($urandom_range(0, 49));
            h = '0;
            if (sel < N) h[sel] = 1'b1;
            p = ($urandom_range(0, 19) == 0);
            frame(pick_rng(1'($urandom_range(0, 1))), h, p);
            if ($urandom_range(0, 39) == 0) hit_only(N'(1) << $urandom_range(0, N - 1));
        end
        @(negedge clk);
        #2 resetN = 1'b0;
        #1 model_reset();
        check_all("async_reset");
        @(negedge clk);
        resetN = 1'b1;
        repeat (3) frame(pick_rng(1'b1), '0, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
